// File: rtl/dec_pkg.sv
// Shared definitions for the instruction-decode stage.
// Provides the 6-bit opcode constants and the bit positions of the
// instruction-word fields used by dec_stage.
package dec_pkg;

    // Opcodes
    localparam logic [5:0] OP_ALU  = 6'b100000;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    // Instruction-word field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RD_MSB     = 20;
    localparam int RD_LSB     = 16;
    localparam int RT_MSB     = 15;
    localparam int RT_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file.
// Ports:
//   clk, rst_n        - clock; asynchronous active-low clear of all registers
//   rd_addr_a/_b      - combinational read addresses
//   rd_data_a/_b      - read data (r0 always reads 0)
//   wr_en, wr_addr,   - synchronous write on rising clk; writes to r0 dropped
//   wr_data
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != 5'd0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No bypass: a read of the register being written returns the old value
    // until the edge.
    assign rd_data_a = (rd_addr_a == 5'd0) ? 32'h0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd0) ? 32'h0 : regs_q[rd_addr_b];

endmodule

// File: rtl/dec_stage.sv
// Instruction-decode stage: register file, read-address selection,
// immediate processing and write-back with byte handling.
// Ports:
//   Clk, Rst_n     - clock; asynchronous active-low reset of the register file
//   Instr          - instruction word
//   RF_WrEn        - write enable for write-back to rd
//   ALU_out,
//   MEM_out        - write-back candidates, chosen by RF_WrData_sel (1 = MEM)
//   RF_B_sel       - port-B read address: 0 = rt, 1 = rd
//   sb, lb         - byte masking of port-B output / write-back data
//   Immed          - processed immediate
//   RF_A           - register[rs]
//   RF_B_or_sb     - port-B data, low byte only when sb
//   lui_out        - {imm, 16'h0000}
module dec_stage
    import dec_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Instr,
    input  logic        RF_WrEn,
    input  logic [31:0] ALU_out,
    input  logic [31:0] MEM_out,
    input  logic        RF_WrData_sel,
    input  logic        RF_B_sel,
    input  logic        sb,
    input  logic        lb,
    output logic [31:0] Immed,
    output logic [31:0] RF_A,
    output logic [31:0] RF_B_or_sb,
    output logic [31:0] lui_out
);

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [4:0]  rd_addr_b;
    logic [31:0] wr_data_raw;
    logic [31:0] wr_data;
    logic [31:0] rf_b;

    assign opcode = Instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = Instr[RS_MSB:RS_LSB];
    assign rd     = Instr[RD_MSB:RD_LSB];
    assign rt     = Instr[RT_MSB:RT_LSB];
    assign imm    = Instr[IMM_MSB:IMM_LSB];

    assign rd_addr_b   = RF_B_sel ? rd : rt;
    assign wr_data_raw = RF_WrData_sel ? MEM_out : ALU_out;
    assign wr_data     = lb ? {24'h0, wr_data_raw[7:0]} : wr_data_raw;

    register_file u_register_file (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .rd_addr_a (rs),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (RF_A),
        .rd_data_b (rf_b),
        .wr_en     (RF_WrEn),
        .wr_addr   (rd),
        .wr_data   (wr_data)
    );

    assign RF_B_or_sb = sb ? {24'h0, rf_b[7:0]} : rf_b;
    assign lui_out    = {imm, 16'h0000};

    always_comb begin
        Immed = {{16{imm[15]}}, imm};
        case (opcode)
            OP_LUI:                Immed = {imm, 16'h0000};
            OP_ANDI, OP_ORI:       Immed = {16'h0000, imm};
            // Branch offsets are word counts, hence the shift by 2.
            OP_BEQ, OP_BNE, OP_B:  Immed = {{14{imm[15]}}, imm, 2'b00};
            OP_LI, OP_ADDI, OP_LB, OP_LW,
            OP_SB, OP_SW, OP_ALU:  Immed = {{16{imm[15]}}, imm};
            default:               Immed = {{16{imm[15]}}, imm};
        endcase
    end

endmodule

// File: tb/tb_dec_stage.sv
module tb_dec_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] Instr;
    logic        RF_WrEn;
    logic [31:0] ALU_out;
    logic [31:0] MEM_out;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic        sb;
    logic        lb;
    logic [31:0] Immed;
    logic [31:0] RF_A;
    logic [31:0] RF_B_or_sb;
    logic [31:0] lui_out;

    always #5 Clk = ~Clk;

    dec_stage dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Instr         (Instr),
        .RF_WrEn       (RF_WrEn),
        .ALU_out       (ALU_out),
        .MEM_out       (MEM_out),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .sb            (sb),
        .lb            (lb),
        .Immed         (Immed),
        .RF_A          (RF_A),
        .RF_B_or_sb    (RF_B_or_sb),
        .lui_out       (lui_out)
    );

    typedef struct {
        string       tag;
        logic [31:0] immed;
        logic [31:0] rf_a;
        logic [31:0] rf_b;
        logic [31:0] lui;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [31:0] model [32];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference immediate: plain arithmetic on the 16-bit field.
    function automatic logic [31:0] ref_immed(input logic [31:0] ins);
        int unsigned op;
        int unsigned uimm;
        int          simm;
        op   = ins >> 26;
        uimm = ins & 32'hFFFF;
        simm = (uimm >= 32768) ? int'(uimm) - 65536 : int'(uimm);
        if (op == 57)                           return 32'(uimm * 65536);
        if (op == 50 || op == 51)               return 32'(uimm);
        if (op == 0 || op == 1 || op == 63)     return 32'(simm * 4);
        return 32'(simm);
    endfunction

    function automatic logic [31:0] reg_val(input int idx);
        if (idx == 0 || Rst_n !== 1'b1) return 32'h0;
        return model[idx];
    endfunction

    // Monitor: outputs are presented once per cycle; compare at the falling edge.
    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check({cur.tag, ".Immed"},      Immed,      cur.immed);
            check({cur.tag, ".RF_A"},       RF_A,       cur.rf_a);
            check({cur.tag, ".RF_B_or_sb"}, RF_B_or_sb, cur.rf_b);
            check({cur.tag, ".lui_out"},    lui_out,    cur.lui);
        end
    end

    // Drive one cycle of stimulus (called at posedge+1), push expected outputs,
    // optionally assert reset mid-cycle, then let the edge commit.
    task automatic drive(input string tag, input logic [31:0] ins, input logic wren,
                         input logic [31:0] alu, input logic [31:0] mem, input logic wsel,
                         input logic bsel, input logic sbv, input logic lbv, input logic rst_mid);
        exp_t        e;
        int          a_idx;
        int          b_idx;
        int          d_idx;
        logic [31:0] b;
        logic [31:0] wd;
        Instr = ins; RF_WrEn = wren; ALU_out = alu; MEM_out = mem;
        RF_WrData_sel = wsel; RF_B_sel = bsel; sb = sbv; lb = lbv;
        if (rst_mid) begin
            #1 Rst_n = 1'b0;
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end
        a_idx = (ins >> 21) & 31;
        d_idx = (ins >> 16) & 31;
        b_idx = bsel ? d_idx : ((ins >> 11) & 31);
        b     = reg_val(b_idx);
        e.tag   = tag;
        e.immed = ref_immed(ins);
        e.rf_a  = reg_val(a_idx);
        e.rf_b  = sbv ? (b % 256) : b;
        e.lui   = 32'(((ins & 32'hFFFF)) * 65536);
        sb_q.push_back(e);
        wd = wsel ? mem : alu;
        if (lbv) wd = wd % 256;
        @(posedge Clk);
        if (Rst_n === 1'b1 && wren && d_idx != 0) model[d_idx] = wd;
        #1;
    endtask

    task automatic read_regs(input string tag, input int ra, input int rb);
        drive(tag, 32'h3C000000 | (ra << 21) | (rb << 16), 1'b0, 32'hDEAD_BEEF,
              32'hFEED_FACE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0]  ops [14];
        logic [31:0] ins;
        int          budget;
        ops = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
                6'b111111, 6'b000000, 6'b000001, 6'b000011, 6'b001111, 6'b000111,
                6'b011111, 6'b101010};
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        Rst_n = 1'b0; Instr = 32'h0; RF_WrEn = 1'b0; ALU_out = 32'h0; MEM_out = 32'h0;
        RF_WrData_sel = 1'b0; RF_B_sel = 1'b0; sb = 1'b0; lb = 1'b0;
        @(posedge Clk); #1;
        // Write attempted while held in reset must be lost.
        drive("reset", 32'hE0210007, 1'b1, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        Rst_n = 1'b1;
        read_regs("post_reset", 1, 1);

        drive("li_r1",  32'hE0010007, 1'b1, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("li_r2",  32'hE0020005, 1'b1, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        read_regs("rd_r1", 2, 1);
        drive("add_r3", 32'h80231030, 1'b1, 32'h0000C00F, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("sb",     32'h1C230005, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive("lb_r4",  32'h0C240005, 1'b1, 32'h0, 32'hCF647855, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive("lui_r5", 32'hE405D807, 1'b1, 32'hD8070000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("beq_p",  32'h0022000A, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("beq_n",  32'h0022FFFA, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("ori",    32'hCC20FFFA, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("wr_r0",  32'hE0001234, 1'b1, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        read_regs("rd_r0", 0, 0);
        read_regs("rd_r3_r4", 3, 4);
        read_regs("rd_r5_r1", 5, 1);
        // Same-cycle write and read of r1: old value before the edge.
        drive("rdw_r1", 32'hE0210099, 1'b1, 32'h99, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        read_regs("rdw_after", 1, 2);

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 3) == 0) ins[31:26] = 6'($urandom);
            drive("rand", ins, 1'($urandom), $urandom, $urandom, 1'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b0);
        end

        // Mid-cycle reset with a write pending: clears at once, write lost.
        read_regs("pre_rst", 1, 2);
        drive("rst_mid", 32'hE0230042, 1'b1, 32'h42, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_regs("rst_r3_r4", 3, 4);
        read_regs("rst_r5_r2", 5, 2);
        Rst_n = 1'b1;
        read_regs("rel_r3_r1", 3, 1);
        for (int n = 0; n < 100; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 13)];
            drive("rand2", ins, 1'($urandom), $urandom, $urandom, 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        budget = 10;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge Clk);
            budget--;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dec_stage.md
# dec_stage

Instruction-decode stage of the single-issue 32-bit datapath, between fetch (IF) and execute (EX). It holds the 32×32 general-purpose register file and selects the register read addresses from the instruction word. It extends or shifts the 16-bit immediate according to the opcode and performs register write-back, with byte handling for `lb`/`sb`. Write-back data arrives from the ALU or from memory in the same cycle.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- `Clk` in 1: clock; register writes occur on the rising edge.
- `Rst_n` in 1: asynchronous active-low reset; clears all registers.
- `Instr` in 32: instruction word. Fields: opcode[31:26], rs[25:21], rd[20:16], rt[15:11], func[5:0], imm[15:0].
- `RF_WrEn` in 1: register-file write enable.
- `ALU_out` in 32: write-back candidate from the ALU.
- `MEM_out` in 32: write-back candidate from data memory.
- `RF_WrData_sel` in 1: selects write data; 0 = `ALU_out`, 1 = `MEM_out`.
- `RF_B_sel` in 1: selects the port-B read address; 0 = rt, 1 = rd.
- `sb` in 1: store-byte mode for the port-B output.
- `lb` in 1: load-byte mode for write-back.
- `Immed` out 32: processed immediate.
- `RF_A` out 32: register[rs].
- `RF_B_or_sb` out 32: port-B data, byte-masked when `sb`=1.
- `lui_out` out 32: {imm, 16'h0000}, driven for every instruction.

## Operation
- Read port A address: rs. Read port B address: `RF_B_sel` ? rd : rt. Both reads are combinational.
- Write address: always rd.
- Write data: `RF_WrData_sel` ? `MEM_out` : `ALU_out`. When `lb`=1, the write data is {24'h0, data[7:0]}, zero-extended.
- r0 reads as 0 always. Writes to r0 are ignored.
- `RF_B_or_sb` = `sb` ? {24'h0, B[7:0]} : B.
- `Immed` by opcode:
  - `lui` 111001: imm << 16.
  - `andi` 110010, `ori` 110011: zero-extend.
  - `beq` 000000, `bne` 000001, `b` 111111: sign-extend then << 2.
  - All others (`li` 111000, `addi` 110000, `lb` 000011, `lw` 001111, `sb` 000111, `sw` 011111, ALU 100000, undefined): sign-extend.
- Everything except register storage is combinational.

## Timing
- Reset: all 32 registers are 0 while `Rst_n`=0, independent of `Clk`. Outputs then reflect zero registers.
- Write: on the rising `Clk` edge when `RF_WrEn`=1, `Rst_n`=1 and rd≠0. Latency is 1 edge.
- Read-during-write to the same register in the same cycle returns the old value until the edge, then the new value. There is no internal bypass.
- Reset asserted mid-cycle clears immediately. A write coinciding with reset assertion is lost.
- `Immed`, `lui_out` and the output muxes settle combinationally within the same cycle as `Instr` and the select inputs change.

## Structure
- Shared package `dec_pkg`:
  - 6-bit opcode constants: ALU, LI, LUI, ADDI, ANDI, ORI, B, BEQ, BNE, LB, LW, SB, SW.
  - Field-position localparams.
- One sub-module, `register_file`: 32×32, two async read ports, one sync write port with enable, async active-low clear, r0 hardwired to zero.
- The immediate extender, write-data mux, lb/sb byte logic and address mux live in `dec_stage`.

## Test plan
- Write and read back via `li`:
  - Stimulus: `Instr`=0xE0010007, `ALU_out`=7, `RF_WrEn`=1, `RF_WrData_sel`=0, `RF_B_sel`=1; one edge.
  - Response: `RF_B_or_sb`=0x00000007 (reads r1), `Immed`=0x00000007.
  - Repeat with 0xE0020005 to load r2=5.
- Register-register ALU write:
  - Stimulus: `add` `Instr`=0x80231030, `RF_B_sel`=0, `ALU_out`=0x0000C00F.
  - Response: `RF_A`=7, `RF_B_or_sb`=5 before the edge; afterward r3=0x0000C00F.
- Store byte:
  - Stimulus: `Instr`=0x1C230005, `sb`=1, `RF_B_sel`=1, `RF_WrEn`=0.
  - Response: `RF_B_or_sb`=0x0000000F, `Immed`=5, no register changes.
- Load byte:
  - Stimulus: `Instr`=0x0C240005, `lb`=1, `RF_WrData_sel`=1, `MEM_out`=0xCF647855.
  - Response: r4=0x00000055.
- `lui` and branch immediates:
  - `Instr`=0xE405D807 → `Immed`=`lui_out`=0xD8070000; with `ALU_out`=0xD8070000, r5 is written with it.
  - `beq` 0x0022000A → `Immed`=0x00000028.
  - 0x0022FFFA → `Immed`=0xFFFFFFE8.
  - `ori` with imm 0xFFFA → `Immed`=0x0000FFFA.
- r0 and reset:
  - Write 0x1234 with rd=0 → reads of r0 return 0.
  - Drive `Rst_n`=0 mid-cycle → `RF_A`/`RF_B_or_sb` for r1..r5 read 0 immediately, with no clock edge required.
